// File: rtl/ras_ctrl.sv
// Return-address-stack controller: forwards fetch push/pop strobes, tracks the
// uncommitted speculative push/pop balance, and unwinds that balance on a flush.
module ras_ctrl #(
    parameter int RAS_SIZE = 16,
    parameter int CNT_W    = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    f_valid,
    input  logic                    f_is_call,
    input  logic                    f_is_ret,
    input  logic [31:0]             f_ret_pc,
    input  logic                    c_valid,
    input  logic                    c_is_call,
    input  logic                    c_is_ret,
    input  logic                    flush,
    output logic                    ras_push,
    output logic                    ras_pop,
    output logic [31:0]             ras_ret_pc_push,
    output logic                    f_ready,
    output logic                    busy,
    output logic signed [CNT_W-1:0] pend_net,
    output logic                    lost
);
    localparam int PC_W    = $clog2(RAS_SIZE + 1);
    localparam int NET_MAX = 2 ** (CNT_W - 1) - 1;
    localparam int NET_MIN = -(2 ** (CNT_W - 1));

    typedef enum logic [1:0] {
        IDLE,
        UNWIND,
        SETTLE
    } state_e;

    state_e                  state_q, state_d;
    logic signed [CNT_W-1:0] pend_q, pend_d;
    logic [PC_W-1:0]         pops_q, pops_d;
    logic                    lost_q, lost_d;

    logic                    push_c;
    logic                    pop_c;
    int                      net_sum;
    logic signed [CNT_W-1:0] net_n;

    function automatic logic signed [CNT_W-1:0] sat_net(input int v);
        if (v > NET_MAX) return CNT_W'(NET_MAX);
        if (v < NET_MIN) return CNT_W'(NET_MIN);
        return CNT_W'(v);
    endfunction

    function automatic logic [PC_W-1:0] pop_limit(input int n);
        if (n > RAS_SIZE) return PC_W'(RAS_SIZE);
        return PC_W'(n);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= '0;
            pops_q  <= '0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            pops_q  <= pops_d;
            lost_q  <= lost_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        pops_d  = pops_q;
        lost_d  = 1'b0;
        push_c  = 1'b0;
        pop_c   = 1'b0;
        f_ready = 1'b0;
        busy    = 1'b0;
        net_sum = int'(pend_q);
        net_n   = pend_q;

        unique case (state_q)
            IDLE: begin
                f_ready = !flush;
                if (f_ready && f_valid) begin
                    // A simultaneous call+return is illegal; it is handled as a call.
                    if (f_is_call) begin
                        push_c  = 1'b1;
                        net_sum = net_sum + 1;
                    end else if (f_is_ret) begin
                        pop_c   = 1'b1;
                        net_sum = net_sum - 1;
                    end
                end
                if (c_valid) begin
                    if (c_is_call)     net_sum = net_sum - 1;
                    else if (c_is_ret) net_sum = net_sum + 1;
                end
                net_n = sat_net(net_sum);

                // Commit has already been folded into net_n when the flush is judged.
                if (flush) begin
                    if (net_n > 0) begin
                        state_d = UNWIND;
                        pend_d  = net_n;
                        pops_d  = pop_limit(int'(net_n));
                    end else begin
                        lost_d  = (net_n < 0);
                        pend_d  = '0;
                    end
                end else begin
                    pend_d = net_n;
                end
            end
            UNWIND: begin
                busy   = 1'b1;
                pop_c  = 1'b1;
                pops_d = pops_q - PC_W'(1);
                if (pops_q <= PC_W'(1)) begin
                    state_d = SETTLE;
                    pend_d  = '0;
                end
            end
            SETTLE: begin
                busy    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes are forced low while reset is held, independent of state.
    assign ras_push        = push_c && !reset;
    assign ras_pop         = pop_c && !reset;
    assign ras_ret_pc_push = push_c ? f_ret_pc : '0;
    assign pend_net        = pend_q;
    assign lost            = lost_q;

endmodule

// File: doc/ras_ctrl.md
RAS_CTRL -- requirements
Module: ras_ctrl

Interface
REQ-001 SHALL have parameter RAS_SIZE, default 16: depth of the controlled return address stack; the maximum number of pops issued per unwind.
REQ-002 SHALL have parameter CNT_W, default 6: width of the signed pending-net counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port f_valid, input, 1 bit: fetch presents a speculative prediction.
REQ-006 SHALL have port f_is_call, input, 1 bit: the predicted instruction is a call (push).
REQ-007 SHALL have port f_is_ret, input, 1 bit: the predicted instruction is a return (pop).
REQ-008 SHALL have port f_ret_pc, input, 32 bits: return address to push for a call.
REQ-009 SHALL have port c_valid, input, 1 bit: commit retires an instruction.
REQ-010 SHALL have port c_is_call, input, 1 bit: the retired instruction is a call.
REQ-011 SHALL have port c_is_ret, input, 1 bit: the retired instruction is a return.
REQ-012 SHALL have port flush, input, 1 bit: pipeline flush (mispredict or exception).
REQ-013 SHALL have port ras_push, output, 1 bit: push strobe to the RAS.
REQ-014 SHALL have port ras_pop, output, 1 bit: pop strobe to the RAS.
REQ-015 SHALL have port ras_ret_pc_push, output, 32 bits: push data to the RAS.
REQ-016 SHALL have port f_ready, output, 1 bit: fetch predictions are accepted this cycle.
REQ-017 SHALL have port busy, output, 1 bit: a recovery sequence is in progress.
REQ-018 SHALL have port pend_net, output, CNT_W bits, signed: uncommitted speculative pushes minus pops.
REQ-019 SHALL have port lost, output, 1 bit: one-cycle pulse when recovery is impossible (net pops were lost).

Function
REQ-020 SHALL implement the FSM states IDLE, UNWIND and SETTLE; f_ready=1 only in IDLE and only when flush=0; busy=1 in UNWIND and SETTLE.
REQ-021 In IDLE with f_ready=1 and f_valid=1: f_is_call SHALL drive ras_push=1 and ras_ret_pc_push=f_ret_pc in the same cycle (combinational); f_is_ret SHALL drive ras_pop=1.
REQ-022 f_is_call and f_is_ret both asserted SHALL be illegal; the bench asserts on it; the RTL SHALL treat it as a call only.
REQ-023 ras_push and ras_pop SHALL never be asserted in the same cycle.
REQ-024 pend_net SHALL be updated as +1 for an accepted call, -1 for an accepted return, -1 for a committed call, +1 for a committed return; both terms SHALL be applied in the same cycle when both occur.
REQ-025 pend_net SHALL saturate at +(2^(CNT_W-1)-1) and -(2^(CNT_W-1)); there SHALL be no wrap-around.
REQ-026 Commit SHALL be counted in IDLE, including in the flush cycle (commit applied before the flush decision); commit SHALL be ignored in UNWIND and SETTLE.
REQ-027 On flush in IDLE, the post-commit value n SHALL be evaluated:
- n>0: go to UNWIND with pop counter = min(n, RAS_SIZE).
- n<0: pulse lost=1 for one cycle, clear pend_net, stay in IDLE.
- n=0: stay in IDLE.
REQ-028 In UNWIND, ras_pop=1 SHALL be asserted every cycle and the counter decremented; after the last pop the FSM SHALL go to SETTLE and pend_net SHALL be cleared.
REQ-029 SETTLE SHALL last exactly 1 cycle, with no RAS strobes, then return to IDLE.
REQ-030 Unwind latency SHALL be: flush at cycle t gives pops in cycles t+1 .. t+k, SETTLE in cycle t+k+1, and f_ready=1 in cycle t+k+2.
REQ-031 flush asserted during UNWIND or SETTLE SHALL be ignored; the sequence completes unchanged.
REQ-032 f_valid while f_ready=0 SHALL have no effect: no strobe and no counter change.

Reset
REQ-033 With reset=1 at a clock edge: state=IDLE, pend_net=0, pop counter=0, lost=0.
REQ-034 While reset=1: ras_push=0 and ras_pop=0 regardless of inputs.
REQ-035 Reset SHALL dominate all inputs; reset asserted mid-UNWIND SHALL abort immediately with no further pops.

Verification
REQ-036 Three accepted calls, no commits, flush -> pend_net=3; ras_pop high for exactly 3 cycles; busy for 4 cycles; f_ready returns on the 5th cycle after flush.
REQ-037 Two calls, then commit of one call in the flush cycle -> exactly 1 pop issued; pend_net=0 afterwards.
REQ-038 One accepted return, flush -> lost pulses for 1 cycle; zero pops; pend_net=0; f_ready stays 1 in the next cycle.
REQ-039 40 calls without commit -> pend_net saturates at 31; flush -> exactly 16 pops issued.
REQ-040 Flush re-asserted mid-UNWIND of 4 pops -> exactly 4 pops total; reset in the 2nd UNWIND cycle -> pops stop at once and pend_net=0.
REQ-041 Fetch call with f_ret_pc=0x8000_1004 in IDLE -> ras_push=1 and ras_ret_pc_push=0x8000_1004 in the same cycle; the same request during busy -> no strobe.
